seg7_scan: RTL

- Consumes the ~100 Hz scan signal from the clock divider and drives a 4-digit multiplexed seven-segment display with the 16-bit ALU result in hex.
- The divider output is treated as data: it is synchronised and edge-detected inside the 50 MHz domain, never used as a clock.
- Double-buffered value register: a new result only appears at a frame boundary, so the display never tears.

---
 rtl/seg7_pkg.sv | 53 +++++
 rtl/tick_sync.sv | 27 ++
 rtl/seg7_scan.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, types and decode helpers for the multiplexed 7-segment scanner.
// Segment data is kept active-low internally; polarity is applied once at the output register.
package seg7_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic       DP_OFF  = 1'b1;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
  } disp_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Converts an active-low display word to board polarity (common-cathode inverts everything).
  function automatic disp_t apply_polarity(input disp_t raw, input bit active_low);
    disp_t res;
    res = raw;
    if (!active_low) begin
      res.an  = ~raw.an;
      res.seg = ~raw.seg;
      res.dp  = ~raw.dp;
    end
    return res;
  endfunction

endpackage

// File: rtl/tick_sync.sv
// Synchroniser plus rising-edge detector: turns a slow asynchronous level into
// single-cycle ticks in the Clk domain. Also suitable for push-button inputs.
module tick_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Async_in,
  output logic Tick_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Async_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign Tick_out = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/seg7_scan.sv
// Four-digit hex scanner: advances one digit per synchronised scan tick and swaps in
// newly loaded values only at frame boundaries so a frame never mixes two values.
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Scan_in,
  input  logic [15:0] Value_in,
  input  logic        Load,
  input  logic [3:0]  Dp_in,
  input  logic        Blank_lz,
  output logic [3:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp,
  output logic [1:0]  Digit_idx
);

  localparam disp_t DISP_OFF_RAW = '{an: AN_OFF, seg: SEG_OFF, dp: DP_OFF, idx: 2'd0};

  logic        tick;
  logic        wrap;

  logic [1:0]  idx_q, idx_d;
  logic        running_q, running_d;
  logic [15:0] pending_q, pending_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pend_flag_q, pend_flag_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_dp_q, shadow_dp_d;
  disp_t       out_q, out_d;

  logic [N_DIGITS-1:0] lz_zero;
  logic [3:0]          nibble;
  disp_t               raw;

  tick_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick_sync (
    .Clk     (Clk),
    .Reset   (Reset),
    .Async_in(Scan_in),
    .Tick_out(tick)
  );

  // The very first tick starts a frame too, so it may pick up a pending value.
  assign wrap = tick && (!running_q || (idx_q == 2'd3));

  always_comb begin
    idx_d       = idx_q;
    running_d   = running_q;
    pending_d   = pending_q;
    pend_dp_d   = pend_dp_q;
    pend_flag_d = pend_flag_q;
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;

    if (tick) begin
      running_d = 1'b1;
      if (running_q) begin
        idx_d = idx_q + 2'd1;
      end
    end

    if (wrap && pend_flag_q) begin
      shadow_d    = pending_q;
      shadow_dp_d = pend_dp_q;
      pend_flag_d = 1'b0;
    end

    // A load on the wrap edge lands in pending and waits for the next frame.
    if (Load) begin
      pending_d   = Value_in;
      pend_dp_d   = Dp_in;
      pend_flag_d = 1'b1;
    end
  end

  genvar gi;
  assign lz_zero[0] = 1'b0;
  generate
    for (gi = 1; gi < N_DIGITS; gi++) begin : g_lz
      assign lz_zero[gi] = (shadow_q[15:4*gi] == '0);
    end
  endgenerate

  always_comb begin
    nibble = shadow_q[{idx_q, 2'b00} +: 4];
    raw    = DISP_OFF_RAW;
    raw.idx = idx_q;
    if (running_q && !(Blank_lz && lz_zero[idx_q])) begin
      raw.an  = ~(4'b0001 << idx_q);
      raw.seg = hex_to_seg(nibble);
      raw.dp  = ~shadow_dp_q[idx_q];
    end
    out_d = apply_polarity(raw, ACTIVE_LOW);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      idx_q       <= 2'd0;
      running_q   <= 1'b0;
      pending_q   <= '0;
      pend_dp_q   <= '0;
      pend_flag_q <= 1'b0;
      shadow_q    <= '0;
      shadow_dp_q <= '0;
      out_q       <= apply_polarity(DISP_OFF_RAW, ACTIVE_LOW);
    end else begin
      idx_q       <= idx_d;
      running_q   <= running_d;
      pending_q   <= pending_d;
      pend_dp_q   <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      shadow_q    <= shadow_d;
      shadow_dp_q <= shadow_dp_d;
      out_q       <= out_d;
    end
  end

  assign An        = out_q.an;
  assign Seg       = out_q.seg;
  assign Dp        = out_q.dp;
  assign Digit_idx = out_q.idx;

endmodule
